// File: rtl/relay_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// state_definitions : one-hot state constants, instruction classes and the
//                     class-to-length mapping shared by sequencer and decode.
// Revision: 1.0
// ============================================================================
package state_definitions;

   localparam int MAX_STATES = 24;

   localparam logic [MAX_STATES-1:0] state_1  = 24'h000001;
   localparam logic [MAX_STATES-1:0] state_2  = 24'h000002;
   localparam logic [MAX_STATES-1:0] state_3  = 24'h000004;
   localparam logic [MAX_STATES-1:0] state_4  = 24'h000008;
   localparam logic [MAX_STATES-1:0] state_5  = 24'h000010;
   localparam logic [MAX_STATES-1:0] state_6  = 24'h000020;
   localparam logic [MAX_STATES-1:0] state_7  = 24'h000040;
   localparam logic [MAX_STATES-1:0] state_8  = 24'h000080;
   localparam logic [MAX_STATES-1:0] state_9  = 24'h000100;
   localparam logic [MAX_STATES-1:0] state_10 = 24'h000200;
   localparam logic [MAX_STATES-1:0] state_11 = 24'h000400;
   localparam logic [MAX_STATES-1:0] state_12 = 24'h000800;
   localparam logic [MAX_STATES-1:0] state_13 = 24'h001000;
   localparam logic [MAX_STATES-1:0] state_14 = 24'h002000;
   localparam logic [MAX_STATES-1:0] state_15 = 24'h004000;
   localparam logic [MAX_STATES-1:0] state_16 = 24'h008000;
   localparam logic [MAX_STATES-1:0] state_17 = 24'h010000;
   localparam logic [MAX_STATES-1:0] state_18 = 24'h020000;
   localparam logic [MAX_STATES-1:0] state_19 = 24'h040000;
   localparam logic [MAX_STATES-1:0] state_20 = 24'h080000;
   localparam logic [MAX_STATES-1:0] state_21 = 24'h100000;
   localparam logic [MAX_STATES-1:0] state_22 = 24'h200000;
   localparam logic [MAX_STATES-1:0] state_23 = 24'h400000;
   localparam logic [MAX_STATES-1:0] state_24 = 24'h800000;

   localparam logic [4:0] c_default_len = 5'd8;

   // GOTO occupies the whole 11xx quadrant; CLS_GOTO is its canonical code.
   typedef enum logic [3:0] {
      CLS_MOV_8  = 4'b0000,
      CLS_SETAB  = 4'b0100,
      CLS_ALU    = 4'b1000,
      CLS_LDST   = 4'b1001,
      CLS_MOV_16 = 4'b1010,
      CLS_INC    = 4'b1011,
      CLS_GOTO   = 4'b1100
   } instr_class_e;

   function automatic logic [4:0] class_length(input logic [3:0] cls);
      logic [4:0] len;
      len = c_default_len;
      casez (cls)
         4'b1001: len = 5'd12;
         4'b1010: len = 5'd10;
         4'b1011: len = 5'd14;
         4'b11??: len = 5'd24;
         default: len = c_default_len;
      endcase
      return len;
   endfunction

   function automatic logic class_is_legal(input logic [3:0] cls);
      logic legal;
      legal = 1'b0;
      casez (cls)
         4'b0000, 4'b0100, 4'b1000,
         4'b1001, 4'b1010, 4'b1011,
         4'b11??: legal = 1'b1;
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage
`default_nettype wire

// File: rtl/relay_sequencer.sv
`default_nettype none
// ============================================================================
// relay_sequencer : one-hot instruction sequencer with RUN/HALTED control.
// Revision: 1.0
// ============================================================================
module relay_sequencer
   import state_definitions::*;
#(
   parameter bit TICK_BYPASS = 1'b0
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic [3:0]            fsm_input,
   input  logic                  halt,
   input  logic                  run,
   output logic [MAX_STATES-1:0] state,
   output logic                  instr_done,
   output logic                  halted,
   output logic                  bad_class
);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } top_state_e;

   top_state_e            r_mode;
   logic [MAX_STATES-1:0] r_state;
   logic [4:0]            r_len;
   logic                  r_halt_pending;
   logic                  r_instr_done;
   logic                  r_bad_class;

   logic                  w_advance;
   logic [4:0]            w_last_idx;
   logic                  w_past_latch;
   logic                  w_is_last;

   assign w_advance    = TICK_BYPASS || tick;
   assign w_last_idx   = r_len - 5'd1;
   // States 1-4 can never be final: the length is only meaningful after latch.
   assign w_past_latch = |r_state[MAX_STATES-1:4];
   assign w_is_last    = w_past_latch && r_state[w_last_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode         <= ST_RUN;
         r_state        <= state_1;
         r_len          <= c_default_len;
         r_halt_pending <= 1'b0;
         r_instr_done   <= 1'b0;
         r_bad_class    <= 1'b0;
      end else begin
         r_instr_done <= 1'b0;
         r_bad_class  <= 1'b0;
         case (r_mode)
            ST_RUN: begin
               if (halt)
                  r_halt_pending <= 1'b1;
               if (w_advance) begin
                  if (r_state[3]) begin
                     r_len       <= class_length(fsm_input);
                     r_bad_class <= !class_is_legal(fsm_input);
                  end
                  if (w_is_last) begin
                     r_instr_done <= 1'b1;
                     if (r_halt_pending || halt) begin
                        r_mode         <= ST_HALTED;
                        r_state        <= '0;
                        r_halt_pending <= 1'b0;
                     end else begin
                        r_state <= state_1;
                     end
                  end else begin
                     r_state <= {r_state[MAX_STATES-2:0], 1'b0};
                  end
               end
            end
            ST_HALTED: begin
               if (run) begin
                  r_mode         <= ST_RUN;
                  r_state        <= state_1;
                  r_halt_pending <= 1'b0;
               end
            end
            default: begin
               r_mode  <= ST_RUN;
               r_state <= state_1;
            end
         endcase
      end
   end

   assign state      = r_state;
   assign instr_done = r_instr_done;
   assign halted     = (r_mode == ST_HALTED);
   assign bad_class  = r_bad_class;

endmodule
`default_nettype wire

// File: tb/tb_relay_sequencer.sv
`default_nettype none
// ============================================================================
// tb_relay_sequencer : directed scenarios plus randomized traffic against a
//                      position/length reference model of the sequencer.
// Revision: 1.0
// ============================================================================
module tb_relay_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic        halt = 1'b0;
   logic        run = 1'b0;
   logic [3:0]  fsm_input = 4'd0;
   logic [23:0] state;
   logic        instr_done;
   logic        halted;
   logic        bad_class;

   int errors = 0;
   int checks = 0;

   relay_sequencer #(.TICK_BYPASS(1'b0)) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .fsm_input  (fsm_input),
      .halt       (halt),
      .run        (run),
      .state      (state),
      .instr_done (instr_done),
      .halted     (halted),
      .bad_class  (bad_class)
   );

   always #5 clk = ~clk;

   // Class table written directly from the opcode list.
   int len_tab[16];
   bit legal_tab[16];
   initial begin
      for (int i = 0; i < 16; i++) begin
         len_tab[i]   = 8;
         legal_tab[i] = 1'b0;
      end
      legal_tab[0]  = 1'b1;
      legal_tab[4]  = 1'b1;
      legal_tab[8]  = 1'b1;
      len_tab[9]    = 12; legal_tab[9]  = 1'b1;
      len_tab[10]   = 10; legal_tab[10] = 1'b1;
      len_tab[11]   = 14; legal_tab[11] = 1'b1;
      for (int i = 12; i < 16; i++) begin
         len_tab[i]   = 24;
         legal_tab[i] = 1'b1;
      end
   end

   // Reference model: current position within the instruction and its length.
   int m_pos = 1;
   int m_len = 8;
   bit m_halted = 1'b0;
   bit m_pend = 1'b0;
   bit m_done = 1'b0;
   bit m_bad = 1'b0;
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      m_done = 1'b0;
      m_bad  = 1'b0;
      if (reset) begin
         m_valid  = 1'b1;
         m_halted = 1'b0;
         m_pend   = 1'b0;
         m_pos    = 1;
         m_len    = 8;
      end else if (m_halted) begin
         if (run) begin
            m_halted = 1'b0;
            m_pend   = 1'b0;
            m_pos    = 1;
         end
      end else begin
         if (halt) m_pend = 1'b1;
         if (tick) begin
            if (m_pos == 4) begin
               m_len = len_tab[fsm_input];
               m_bad = !legal_tab[fsm_input];
            end
            if (m_pos >= 5 && m_pos == m_len) begin
               m_done = 1'b1;
               if (m_pend) begin
                  m_halted = 1'b1;
                  m_pend   = 1'b0;
               end else begin
                  m_pos = 1;
               end
            end else begin
               m_pos = m_pos + 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("model.state", {8'd0, state},
               m_halted ? 32'd0 : (32'd1 << (m_pos - 1)));
         check("model.halted", {31'd0, halted}, {31'd0, m_halted});
         check("model.instr_done", {31'd0, instr_done}, {31'd0, m_done});
         check("model.bad_class", {31'd0, bad_class}, {31'd0, m_bad});
         check("onehot", {31'd0, (halted ? (state == 24'd0) : $onehot(state))}, 32'd1);
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs one instruction from state_1 entry; counts clks until instr_done.
   task automatic run_instr(input logic [3:0] cls, input int period, input int halt_at,
                            output int clks, output int bads);
      int c;
      c = 0;
      bads = 0;
      fsm_input = cls;
      do begin
         c++;
         tick = ((c % period) == 0);
         halt = (halt_at != 0) && state[halt_at-1];
         cyc();
         if (bad_class) bads++;
      end while (!instr_done && c < 400);
      tick = 1'b0;
      halt = 1'b0;
      check("instr_timeout", {31'd0, instr_done}, 32'd1);
      clks = c;
   endtask

   initial begin
      int clks;
      int bads;
      int n;

      @(negedge clk);
      cyc();
      reset = 1'b0;
      check("reset.state", {8'd0, state}, 32'h1);
      check("reset.halted", {31'd0, halted}, 32'd0);
      check("reset.instr_done", {31'd0, instr_done}, 32'd0);
      check("reset.bad_class", {31'd0, bad_class}, 32'd0);

      run_instr(4'b0000, 1, 0, clks, bads);
      check("mov8.clks", clks, 32'd8);
      check("mov8.back_to_state1", {8'd0, state}, 32'h1);
      cyc();
      check("mov8.done_width", {31'd0, instr_done}, 32'd0);

      run_instr(4'b1101, 3, 0, clks, bads);
      check("goto.clks", clks, 32'd72);
      check("goto.back_to_state1", {8'd0, state}, 32'h1);
      cyc();
      check("goto.done_width", {31'd0, instr_done}, 32'd0);

      run_instr(4'b1011, 1, 0, clks, bads);
      check("inc.clks", clks, 32'd14);
      run_instr(4'b1010, 1, 0, clks, bads);
      check("mov16.clks", clks, 32'd10);

      run_instr(4'b0110, 1, 0, clks, bads);
      check("badcls.clks", clks, 32'd8);
      check("badcls.pulses", bads, 32'd1);

      run_instr(4'b1010, 1, 9, clks, bads);
      check("halt.clks", clks, 32'd10);
      check("halt.state", {8'd0, state}, 32'd0);
      check("halt.halted", {31'd0, halted}, 32'd1);
      tick = 1'b1;
      repeat (5) cyc();
      tick = 1'b0;
      check("halt.tick_ignored", {8'd0, state}, 32'd0);
      run = 1'b1;
      cyc();
      run = 1'b0;
      check("resume.state", {8'd0, state}, 32'h1);
      check("resume.halted", {31'd0, halted}, 32'd0);

      fsm_input = 4'b1100;
      n = 0;
      while (!state[16] && n < 40) begin
         tick = 1'b1;
         cyc();
         n++;
      end
      check("goto.reached_state17", {8'd0, state}, 32'h10000);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      tick = 1'b0;
      check("midreset.state", {8'd0, state}, 32'h1);
      check("midreset.halted", {31'd0, halted}, 32'd0);
      run_instr(4'b0000, 1, 0, clks, bads);
      check("midreset.mov8_clks", clks, 32'd8);

      for (int i = 0; i < 4000; i++) begin
         reset     = ($urandom_range(0, 249) == 0);
         tick      = ($urandom_range(0, 2) != 0);
         halt      = ($urandom_range(0, 39) == 0);
         run       = ($urandom_range(0, 5) == 0);
         fsm_input = 4'($urandom_range(0, 15));
         cyc();
      end
      reset = 1'b0;
      tick  = 1'b0;
      halt  = 1'b0;
      run   = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
